// File: rtl/apb_master_bridge_if.sv
// APB4 bus bundle shared by the bridge (master side) and APB peripherals (slave side).
interface ApbIO #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: valid/ready request in, SETUP/ACCESS on APB,
// one-entry response buffer out, with an optional ACCESS-phase timeout abort.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module apb_master_bridge #(
    parameter int ADDR_WIDTH     = `PADDR_SIZE,
    parameter int DATA_WIDTH     = `XLEN,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
    // valid never waits on ready, and req_ready never looks at req_valid.
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    resp_timeout,
    ApbIO.master                    apb,
    output logic [1:0]              dbg_state
);

    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 accept;
    logic                 done;
    logic                 abort;

    assign dbg_state = state;

    always_comb begin
        req_ready  = (state == IDLE) && (!resp_valid || resp_ready);
        accept     = req_valid && req_ready;
        done       = (state == ACCESS) && apb.pready;
        // pready wins over the timeout when both land in the same cycle
        abort      = (state == ACCESS) && !apb.pready && (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (done || abort) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Strobes follow the next state so they are registered outputs; address/data
    // phase signals only change on accept and so stay put through IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pprot   <= '0;
            apb.pwdata  <= '0;
            apb.pstrb   <= '0;
        end else begin
            apb.psel    <= (next_state != IDLE);
            apb.penable <= (next_state == ACCESS);
            if (accept) begin
                apb.paddr  <= req_addr;
                apb.pprot  <= req_prot;
                apb.pwrite <= req_write;
                apb.pwdata <= req_write ? req_wdata : '0;
                apb.pstrb  <= req_write ? req_strb : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      cnt <= '0;
        else if ((state == ACCESS) && !done && !abort) cnt <= cnt + CNT_WIDTH'(1);
        else                                           cnt <= '0;
    end

    // A completion can only arrive once the buffer has drained, so it may overwrite freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            if (resp_valid && resp_ready) resp_valid <= 1'b0;
            if (done) begin
                resp_valid   <= 1'b1;
                resp_rdata   <= apb.pwrite ? '0 : apb.prdata;
                resp_err     <= apb.pslverr;
                resp_timeout <= 1'b0;
            end else if (abort) begin
                resp_valid   <= 1'b1;
                resp_rdata   <= '0;
                resp_err     <= 1'b1;
                resp_timeout <= 1'b1;
            end
        end
    end

endmodule
